// File: rtl/cr_lz77_decomp_expand.sv
// LZ77 token expander: rebuilds the byte stream from literal/match tokens via a circular history.
// Optional counters enabled by CR_LZ77_DECOMP_STATS_EN.
module cr_lz77_decomp_expand #(
   parameter int unsigned IN_BYTES   = 4,
   parameter int unsigned HIST_DEPTH = 4096,
   parameter int unsigned OFF_W      = 13,
   parameter int unsigned LEN_W      = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tok_vld,
   output logic                  tok_rdy,
   input  logic                  tok_is_match,
   input  logic [IN_BYTES*8-1:0] tok_lit,
   input  logic [2:0]            tok_lit_cnt,
   input  logic [LEN_W-1:0]      tok_len,
   input  logic [OFF_W-1:0]      tok_off,
   input  logic                  tok_last,
   output logic [IN_BYTES*8-1:0] out_data,
   output logic [IN_BYTES-1:0]   out_bytes_vld,
   output logic                  out_last,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic                  err_pulse,
   output logic                  err_sticky
`ifdef CR_LZ77_DECOMP_STATS_EN
   ,
   output logic [31:0]           stat_lit_bytes,
   output logic [31:0]           stat_match_bytes,
   output logic [15:0]           stat_err_cnt
`endif
);

   localparam int unsigned AW = $clog2(HIST_DEPTH);
   localparam int unsigned DW = IN_BYTES * 8;
   localparam logic [OFF_W-1:0] DEPTH_OFF = OFF_W'(HIST_DEPTH);
   localparam logic [OFF_W:0]   DEPTH_SUM = (OFF_W + 1)'(HIST_DEPTH);

   typedef enum logic {IDLE, COPY} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              last_q, last_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [OFF_W-1:0]  hist_cnt_q, hist_cnt_d;
   logic [DW-1:0]     out_data_d;
   logic [IN_BYTES-1:0] out_bytes_vld_d;
   logic              out_last_d, out_vld_d, err_pulse_d, err_sticky_d;
   logic [IN_BYTES-1:0] we;
   logic [DW-1:0]     wdata, lit_masked, cp_masked;
   logic [7:0]        hist [HIST_DEPTH];
   logic              can_load, acc, lit_ok, match_ok, copy_load;
   logic [2:0]        cp_n;

   function automatic logic [IN_BYTES-1:0] therm(input logic [2:0] c);
      return IN_BYTES'(((IN_BYTES + 1)'(1) << c) - (IN_BYTES + 1)'(1));
   endfunction

   function automatic logic [OFF_W-1:0] sat_add(input logic [OFF_W-1:0] c, input logic [2:0] n);
      logic [OFF_W:0] s;
      s = {1'b0, c} + (OFF_W + 1)'(n);
      return (s > DEPTH_SUM) ? DEPTH_OFF : s[OFF_W-1:0];
   endfunction

   // Byte lane whose value lane i repeats when the distance is shorter than a beat.
   function automatic logic [1:0] fwd_idx(input logic [OFF_W-1:0] off, input int i);
      case (off)
         OFF_W'(1): return 2'd0;
         OFF_W'(2): return 2'(i) & 2'b01;
         OFF_W'(3): return (i == 3) ? 2'd0 : 2'(i);
         default:   return 2'(i);
      endcase
   endfunction

   assign can_load  = !out_vld || out_rdy;
   assign tok_rdy   = rst_n && (state_q == IDLE) && can_load;
   assign acc       = tok_vld && tok_rdy;
   assign lit_ok    = (tok_lit_cnt != 3'd0) && (tok_lit_cnt <= 3'd4);
   assign match_ok  = (tok_off != '0) && (tok_off <= hist_cnt_q) && (tok_off <= DEPTH_OFF)
                      && (tok_len >= LEN_W'(3));
   assign copy_load = (state_q == COPY) && can_load;
   assign cp_n      = (rem_q >= LEN_W'(4)) ? 3'd4 : rem_q[2:0];

   always_comb begin
      lit_masked = '0;
      cp_masked  = '0;
      for (int i = 0; i < IN_BYTES; i++) begin
         if (3'(i) < tok_lit_cnt) lit_masked[i*8 +: 8] = tok_lit[i*8 +: 8];
         if (3'(i) < cp_n)
            cp_masked[i*8 +: 8] = hist[wr_ptr_q + AW'(fwd_idx(off_q, i)) - off_q[AW-1:0]];
      end
   end

   // Next-state, output-stage and history-write decode.
   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      off_d           = off_q;
      last_d          = last_q;
      wr_ptr_d        = wr_ptr_q;
      hist_cnt_d      = hist_cnt_q;
      out_data_d      = out_data;
      out_bytes_vld_d = out_bytes_vld;
      out_last_d      = out_last;
      out_vld_d       = out_vld && !out_rdy;
      err_pulse_d     = 1'b0;
      err_sticky_d    = err_sticky;
      we              = '0;
      wdata           = '0;
      case (state_q)
         IDLE: begin
            if (acc && !tok_is_match && lit_ok) begin
               out_data_d      = lit_masked;
               out_bytes_vld_d = therm(tok_lit_cnt);
               out_last_d      = tok_last;
               out_vld_d       = 1'b1;
               we              = therm(tok_lit_cnt);
               wdata           = lit_masked;
               wr_ptr_d        = wr_ptr_q + AW'(tok_lit_cnt);
               hist_cnt_d      = tok_last ? '0 : sat_add(hist_cnt_q, tok_lit_cnt);
            end else if (acc && tok_is_match && match_ok) begin
               rem_d   = tok_len;
               off_d   = tok_off;
               last_d  = tok_last;
               state_d = COPY;
            end else if (acc) begin
               err_pulse_d  = 1'b1;
               err_sticky_d = 1'b1;
               if (tok_last) begin
                  out_data_d      = '0;
                  out_bytes_vld_d = '0;
                  out_last_d      = 1'b1;
                  out_vld_d       = 1'b1;
                  hist_cnt_d      = '0;
               end
            end
         end
         COPY: begin
            if (can_load) begin
               out_data_d      = cp_masked;
               out_bytes_vld_d = therm(cp_n);
               out_vld_d       = 1'b1;
               we              = therm(cp_n);
               wdata           = cp_masked;
               wr_ptr_d        = wr_ptr_q + AW'(cp_n);
               rem_d           = rem_q - LEN_W'(cp_n);
               out_last_d      = 1'b0;
               hist_cnt_d      = sat_add(hist_cnt_q, cp_n);
               if (rem_q <= LEN_W'(4)) begin
                  state_d    = IDLE;
                  out_last_d = last_q;
                  if (last_q) hist_cnt_d = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         off_q         <= '0;
         last_q        <= 1'b0;
         wr_ptr_q      <= '0;
         hist_cnt_q    <= '0;
         out_data      <= '0;
         out_bytes_vld <= '0;
         out_last      <= 1'b0;
         out_vld       <= 1'b0;
         err_pulse     <= 1'b0;
         err_sticky    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         off_q         <= off_d;
         last_q        <= last_d;
         wr_ptr_q      <= wr_ptr_d;
         hist_cnt_q    <= hist_cnt_d;
         out_data      <= out_data_d;
         out_bytes_vld <= out_bytes_vld_d;
         out_last      <= out_last_d;
         out_vld       <= out_vld_d;
         err_pulse     <= err_pulse_d;
         err_sticky    <= err_sticky_d;
      end
   end

   // History storage: contents need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_BYTES; i++)
         if (we[i]) hist[wr_ptr_q + AW'(i)] <= wdata[i*8 +: 8];
   end

`ifdef CR_LZ77_DECOMP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lit_bytes   <= '0;
         stat_match_bytes <= '0;
         stat_err_cnt     <= '0;
      end else begin
         if (acc && !tok_is_match && lit_ok) stat_lit_bytes <= stat_lit_bytes + 32'(tok_lit_cnt);
         if (copy_load) stat_match_bytes <= stat_match_bytes + 32'(cp_n);
         if (err_pulse_d) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cr_lz77_decomp_expand.sv
// Bench for cr_lz77_decomp_expand: byte-stream reference model plus directed token vectors.
module tb_cr_lz77_decomp_expand;

   localparam int D = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tok_vld, tok_rdy, tok_is_match, tok_last;
   logic [31:0] tok_lit;
   logic [2:0]  tok_lit_cnt;
   logic [8:0]  tok_len;
   logic [12:0] tok_off;
   logic [31:0] out_data;
   logic [3:0]  out_bytes_vld;
   logic        out_last, out_vld, out_rdy, err_pulse, err_sticky;
`ifdef CR_LZ77_DECOMP_STATS_EN
   logic [31:0] stat_lit_bytes, stat_match_bytes;
   logic [15:0] stat_err_cnt;
`endif

   always #5 clk = ~clk;

   cr_lz77_decomp_expand dut (
      .clk(clk), .rst_n(rst_n), .tok_vld(tok_vld), .tok_rdy(tok_rdy),
      .tok_is_match(tok_is_match), .tok_lit(tok_lit), .tok_lit_cnt(tok_lit_cnt),
      .tok_len(tok_len), .tok_off(tok_off), .tok_last(tok_last),
      .out_data(out_data), .out_bytes_vld(out_bytes_vld), .out_last(out_last),
      .out_vld(out_vld), .out_rdy(out_rdy), .err_pulse(err_pulse), .err_sticky(err_sticky)
`ifdef CR_LZ77_DECOMP_STATS_EN
      , .stat_lit_bytes(stat_lit_bytes), .stat_match_bytes(stat_match_bytes),
      .stat_err_cnt(stat_err_cnt)
`endif
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  vld;
      logic        last;
   } beat_t;

   beat_t        exp_q[$];
   byte unsigned mem[$];
   byte unsigned scratch[$];
   int           hcnt = 0;
   int           err_exp = 0;
   int           err_seen = 0;
   int           n_pass = 0;
   int           n_chk = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: the stream is a flat byte list; each token's bytes are cut into 4-byte beats.
   task automatic emit(input bit last);
      for (int s = 0; s < scratch.size(); s += 4) begin
         beat_t e;
         e = '0;
         for (int j = 0; j < 4; j++)
            if (s + j < scratch.size()) begin
               e.data[8*j +: 8] = scratch[s+j];
               e.vld[j] = 1'b1;
            end
         e.last = last && (s + 4 >= scratch.size());
         exp_q.push_back(e);
      end
      scratch.delete();
   endtask

   task automatic model_err(input bit last);
      err_exp++;
      if (last) begin
         exp_q.push_back(beat_t'{32'h0, 4'h0, 1'b1});
         hcnt = 0;
      end
   endtask

   task automatic model_lit(input logic [31:0] d, input int cnt, input bit last);
      if (cnt < 1 || cnt > 4) begin
         model_err(last);
         return;
      end
      for (int j = 0; j < cnt; j++) begin
         mem.push_back(d[8*j +: 8]);
         scratch.push_back(d[8*j +: 8]);
      end
      emit(last);
      hcnt = last ? 0 : ((hcnt + cnt > D) ? D : hcnt + cnt);
   endtask

   task automatic model_match(input int len, input int off, input bit last);
      if (off == 0 || off > hcnt || off > D || len < 3) begin
         model_err(last);
         return;
      end
      for (int k = 0; k < len; k++) begin
         byte unsigned b;
         b = mem[mem.size() - off];
         mem.push_back(b);
         scratch.push_back(b);
      end
      emit(last);
      hcnt = last ? 0 : ((hcnt + len > D) ? D : hcnt + len);
   endtask

   task automatic drive_tok(input bit m, input logic [31:0] d, input int cnt, input int len,
                            input int off, input bit last);
      bit acc;
      int w;
      @(posedge clk); #1;
      tok_is_match = m;  tok_lit = d;  tok_lit_cnt = 3'(cnt);
      tok_len = 9'(len); tok_off = 13'(off); tok_last = last; tok_vld = 1'b1;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 100) begin
         @(negedge clk);
         acc = tok_rdy;
         @(posedge clk); #1;
         w++;
      end
      tok_vld = 1'b0;
      if (!acc) chk("tok_accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic lit_t(input logic [31:0] d, input int cnt, input bit last);
      model_lit(d, cnt, last);
      drive_tok(1'b0, d, cnt, 0, 0, last);
   endtask

   task automatic mat_t(input int len, input int off, input bit last);
      model_match(len, off, last);
      drive_tok(1'b1, 32'h0, 1, len, off, last);
   endtask

   // Compare process: every transferred beat against the model, stability while stalled.
   initial begin
      logic [37:0] prev;
      bit          prev_stall;
      beat_t       e;
      int          nb;
      prev_stall = 1'b0;
      prev = '0;
      nb = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_stall)
               chk("stall_stable", 64'({out_vld, out_data, out_bytes_vld, out_last}), 64'(prev));
            if (out_vld && out_rdy) begin
               if (exp_q.size() == 0) chk("unexpected_beat", 64'(out_vld), 64'd0);
               else begin
                  e = exp_q.pop_front();
                  chk($sformatf("beat%0d", nb), 64'({out_data, out_bytes_vld, out_last}), 64'(e));
               end
               nb++;
            end
            prev_stall = out_vld && !out_rdy;
            prev = {out_vld, out_data, out_bytes_vld, out_last};
            if (err_pulse) err_seen++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sz, low, w;
      rst_n = 1'b0; tok_vld = 1'b0; tok_is_match = 1'b0; tok_lit = '0; tok_lit_cnt = '0;
      tok_len = '0; tok_off = '0; tok_last = 1'b0; out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({out_vld, out_data, out_bytes_vld, out_last, err_pulse,
                                 err_sticky, tok_rdy}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_reset", 64'(tok_rdy), 64'd1);

      // "ABCD"
      sz = exp_q.size();
      model_lit(32'h44434241, 4, 1'b0);
      chk("pin_abcd", 64'(exp_q[sz]), 64'({32'h44434241, 4'hF, 1'b0}));
      drive_tok(1'b0, 32'h44434241, 4, 0, 0, 1'b0);

      // "AB" then overlapping match len 7 off 2
      sz = exp_q.size();
      model_lit(32'h00004241, 2, 1'b0);
      model_match(7, 2, 1'b0);
      chk("pin_ab", 64'(exp_q[sz]), 64'({32'h00004241, 4'h3, 1'b0}));
      chk("pin_m7a", 64'(exp_q[sz+1]), 64'({32'h42414241, 4'hF, 1'b0}));
      chk("pin_m7b", 64'(exp_q[sz+2]), 64'({32'h00414241, 4'h7, 1'b0}));
      drive_tok(1'b0, 32'h00004241, 2, 0, 0, 1'b0);
      drive_tok(1'b1, 32'h0, 1, 7, 2, 1'b0);
      low = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (tok_rdy) break;
         low++;
         @(posedge clk); #1;
      end
      chk("rdy_low_cycles", 64'(low), 64'd2);

      // "x" then run-length match ending the frame
      sz = exp_q.size();
      model_lit(32'h00000078, 1, 1'b0);
      model_match(5, 1, 1'b1);
      chk("pin_x_run_a", 64'(exp_q[sz+1]), 64'({32'h78787878, 4'hF, 1'b0}));
      chk("pin_x_run_b", 64'(exp_q[sz+2]), 64'({32'h00000078, 4'h1, 1'b1}));
      drive_tok(1'b0, 32'h00000078, 1, 0, 0, 1'b0);
      drive_tok(1'b1, 32'h0, 1, 5, 1, 1'b1);
      @(negedge clk);
      chk("sticky_clear", 64'(err_sticky), 64'd0);

      // History count cleared by frame end: off 1 is now illegal
      mat_t(3, 1, 1'b0);
      @(negedge clk);
      chk("err_pulse_hi", 64'(err_pulse), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_pulse_lo", 64'(err_pulse), 64'd0);
      chk("sticky_set", 64'(err_sticky), 64'd1);

      // Match len 12 off 4 with a 3-cycle downstream stall mid-copy
      sz = exp_q.size();
      model_lit(32'h34333231, 4, 1'b0);
      model_match(12, 4, 1'b1);
      chk("pin_m12_last", 64'(exp_q[sz+3]), 64'({32'h34333231, 4'hF, 1'b1}));
      drive_tok(1'b0, 32'h34333231, 4, 0, 0, 1'b0);
      drive_tok(1'b1, 32'h0, 1, 12, 4, 1'b1);
      @(posedge clk); #1;
      out_rdy = 1'b0;
      @(negedge clk);
      chk("stall_data", 64'(out_data), 64'h34333231);
      repeat (3) begin @(posedge clk); #1; end
      out_rdy = 1'b1;

      // "AB" then too-distant match, then a legal one
      lit_t(32'h00004241, 2, 1'b0);
      mat_t(3, 5, 1'b0);
      @(negedge clk);
      chk("err5_pulse", 64'(err_pulse), 64'd1);
      sz = exp_q.size();
      model_match(3, 2, 1'b1);
      chk("pin_aba", 64'(exp_q[sz]), 64'({32'h00414241, 4'h7, 1'b1}));
      drive_tok(1'b1, 32'h0, 1, 3, 2, 1'b1);

      // Remaining illegal forms; last one ends the frame with an empty beat
      lit_t(32'h54535251, 4, 1'b0);
      mat_t(2, 1, 1'b0);
      lit_t(32'h11111111, 0, 1'b0);
      lit_t(32'h22222222, 5, 1'b0);
      sz = exp_q.size();
      model_match(3, 0, 1'b1);
      chk("pin_empty_last", 64'(exp_q[sz]), 64'({32'h0, 4'h0, 1'b1}));
      drive_tok(1'b1, 32'h0, 1, 3, 0, 1'b1);

      // 4100 bytes of index pattern, then full-depth match across the pointer wrap
      for (int t = 0; t < 1025; t++)
         lit_t({8'(4*t+3), 8'(4*t+2), 8'(4*t+1), 8'(4*t)}, 4, 1'b0);
      sz = exp_q.size();
      model_match(4, 4096, 1'b0);
      chk("pin_wrap", 64'(exp_q[sz]), 64'({32'h07060504, 4'hF, 1'b0}));
      drive_tok(1'b1, 32'h0, 1, 4, 4096, 1'b0);
      mat_t(3, 4097, 1'b0);
      sz = exp_q.size();
      model_match(258, 3, 1'b1);
      chk("pin_len258_beats", 64'(exp_q.size() - sz), 64'd65);
      chk("pin_len258_tail", 64'({exp_q[sz+64].vld, exp_q[sz+64].last}), 64'({4'h3, 1'b1}));
      drive_tok(1'b1, 32'h0, 1, 258, 3, 1'b1);

      w = 0;
      while (exp_q.size() > 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      chk("err_count", 64'(err_seen), 64'(err_exp));
      chk("sticky_end", 64'(err_sticky), 64'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
